// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the latency-counter width and the byte-lane
// count used by the array write logic.
package dmem_pkg;

  // Latency counter width; total request latency is capped at 15.
  localparam int CNT_W = 4;

  // Bytes per data word; one write-enable bit per byte lane.
  localparam int BYTES = 4;

  // Largest value the random-latency LFSR can add to LATENCY.
  localparam int MAX_RAND_EXTRA = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lfsr.sv
// dmem_lfsr: 4-bit maximal-length Fibonacci LFSR, polynomial x^4 + x^3 + 1.
// Loads `seed` while reset is high and advances one position per cycle in
// which `step` is high. The seed must be nonzero or the register locks up.
module dmem_lfsr
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] seed,
  input  logic             step,
  output logic [CNT_W-1:0] value
);

  // Shift left, feeding back the XOR of the two tap bits (stages 4 and 3).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (step) begin
      value <= {value[2:0], value[3] ^ value[2]};
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data SRAM for the MEM stage of the pipeline.
// Serves one request at a time: a word read (we == 0) or a byte-enabled
// write. The response pulse (data_ready for writes, data_valid for reads)
// appears LATENCY cycles after acceptance, after which the block holds off
// until the MEM stage drops mem_done to retire the request.
// Optional feature: define DMEM_RAND_LATENCY_EN to add 0..7 cycles of
// pseudo-random latency per request from a 4-bit LFSR seeded with LFSR_SEED.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int             ADDR_W    = 10,
  parameter int             LATENCY   = 1,
  parameter logic [CNT_W-1:0] LFSR_SEED = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [3:0]  write_we,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        mem_done,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] read_data,
  output logic        busy
);

`ifdef DMEM_RAND_LATENCY_EN
  localparam int MAX_EXTRA = MAX_RAND_EXTRA;
`else
  localparam int MAX_EXTRA = 0;
`endif

  // Reject configurations whose worst-case latency does not fit the counter.
  if (LATENCY < 1 || LATENCY + MAX_EXTRA > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range for the 4-bit counter");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("dmem_responder: LFSR_SEED must be nonzero");
  end

  localparam int DEPTH = 2 ** ADDR_W;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   lat_req;
  logic               accept;
  logic               access;

  // Captured request.
  logic [ADDR_W-1:0]  req_addr;
  logic [3:0]         req_we;
  logic [31:0]        req_data;

  // Request fields seen by the array on the edge that enters RESP.
  logic [ADDR_W-1:0]  acc_addr;
  logic [3:0]         acc_we;
  logic [31:0]        acc_data;
  logic               mem_wr;
  logic               mem_rd;

  logic [31:0]        mem [DEPTH];

  // Byte offset and address bits above the array are don't-care: they alias.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{write_addr[31:ADDR_W+2], write_addr[1:0]};

  assign accept = (state == ST_IDLE) && write_en;

`ifdef DMEM_RAND_LATENCY_EN
  logic [CNT_W-1:0] lfsr_value;
  logic             unused_lfsr_msb;

  dmem_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .step  (accept),
    .value (lfsr_value)
  );

  // The value current at acceptance sets this request's extra latency.
  assign lat_req         = CNT_W'(LATENCY) + {1'b0, lfsr_value[2:0]};
  assign unused_lfsr_msb = lfsr_value[3];
`else
  assign lat_req = CNT_W'(LATENCY);
`endif

  // State and latency counter register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; `access` marks the edge entering RESP.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (write_en) begin
          if (lat_req == CNT_W'(1)) begin
            state_nxt = ST_RESP;
            access    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = lat_req - CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt_nxt == '0) begin
          state_nxt = ST_RESP;
          access    = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!mem_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the request on acceptance; bus inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= '0;
      req_we   <= '0;
      req_data <= '0;
    end else if (accept) begin
      req_addr <= write_addr[ADDR_W+1:2];
      req_we   <= write_we;
      req_data <= write_data;
    end
  end

  // With LATENCY 1 the access happens on the accepting edge, so the array
  // takes the live bus; otherwise it uses the captured request.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_addr = write_addr[ADDR_W+1:2];
      acc_we   = write_we;
      acc_data = write_data;
    end else begin
      acc_addr = req_addr;
      acc_we   = req_we;
      acc_data = req_data;
    end
  end

  // Reset holds the FSM in IDLE; the gate stops a live request on the bus
  // from reaching the array while reset is asserted.
  assign mem_wr = access && !rst && (acc_we != 4'b0000);
  assign mem_rd = access && (acc_we == 4'b0000);

  // Byte-lane array writes.
  // NOTE: the array has no reset; its contents survive rst, and a resettable
  // array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (acc_we[b]) begin
          mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
        end
      end
    end
  end

  // Read word register; holds its value until the next read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (mem_rd) begin
      read_data <= mem[acc_addr];
    end
  end

  assign data_ready = (state == ST_RESP) && (req_we != 4'b0000);
  assign data_valid = (state == ST_RESP) && (req_we == 4'b0000);
  assign busy       = (state != ST_IDLE);

endmodule
